// File: rtl/qpmm_arbiter.sv
// Round-robin front end sharing one fixed-latency, non-stalling QPMM multiplier among NREQ requesters.
// Optional perf_issue/perf_idle counters are built when QPMM_ARB_PERF_EN is defined.
module qpmm_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 286,
  parameter int BW   = 286,
  parameter int ZW   = 286,
  parameter int LAT  = 46
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_a,
  input  logic [NREQ*BW-1:0] req_b,
  output logic [AW-1:0]      mul_a,
  output logic [BW-1:0]      mul_b,
  input  logic [ZW-1:0]      mul_z,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [ZW-1:0]      rsp_z,
`ifdef QPMM_ARB_PERF_EN
  output logic [31:0]        perf_issue,
  output logic [31:0]        perf_idle,
`endif
  output logic               busy
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST   = IW'(NREQ-1);

  logic [IW-1:0]            rr;
  logic [NREQ-1:0]          rot;
  logic [IW-1:0]            off, gnt_idx;
  logic [IW:0]              sum;
  logic                     found, accept;
  logic [AW-1:0]            sel_a;
  logic [BW-1:0]            sel_b;
  logic [LAT:0]             vld_pipe;
  logic [LAT:0][IW-1:0]     id_pipe;

  // Rotate requests so that bit 0 is the requester at rr; the lowest set bit wins.
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> rr);
    found = 1'b0;
    off   = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    sum     = {1'b0, rr} + {1'b0, off};
    gnt_idx = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
    req_ready = '0;
    if (found && rstn) req_ready[gnt_idx] = 1'b1;
  end

  assign accept = |req_ready;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_a = req_a[i*AW +: AW];
        sel_b = req_b[i*BW +: BW];
      end
    end
  end

  // The multiplier cannot stall, so the tag pipe shifts every cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr        <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      rsp_valid <= '0;
      rsp_z     <= '0;
    end else begin
      mul_a    <= accept ? sel_a : '0;
      mul_b    <= accept ? sel_b : '0;
      if (accept) rr <= (gnt_idx == LAST) ? '0 : gnt_idx + IW'(1);
      vld_pipe <= {vld_pipe[LAT-1:0], accept};
      id_pipe  <= {id_pipe[LAT-1:0], gnt_idx};
      rsp_valid <= '0;
      if (vld_pipe[LAT]) begin
        rsp_valid <= NREQ'(1) << id_pipe[LAT];
        rsp_z     <= mul_z;
      end
    end
  end

  assign busy = (|vld_pipe) | (|rsp_valid);

`ifdef QPMM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_issue <= '0;
      perf_idle  <= '0;
    end else if (accept) begin
      perf_issue <= perf_issue + 32'd1;
    end else begin
      perf_idle  <= perf_idle + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qpmm_arbiter.sv
// Randomized bench for qpmm_arbiter against a queue-based transaction model and a delay-line multiplier.
module tb_qpmm_arbiter;
  localparam int NREQ = 4, AW = 64, BW = 64, ZW = 64, LAT = 46;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_a = '0;
  logic [NREQ*BW-1:0] req_b = '0;
  logic [AW-1:0]      mul_a;
  logic [BW-1:0]      mul_b;
  logic [ZW-1:0]      mul_z;
  logic [NREQ-1:0]    rsp_valid;
  logic [ZW-1:0]      rsp_z;
  logic               busy;
`ifdef QPMM_ARB_PERF_EN
  logic [31:0]        perf_issue, perf_idle;
`endif

  qpmm_arbiter #(.NREQ(NREQ), .AW(AW), .BW(BW), .ZW(ZW), .LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z),
`ifdef QPMM_ARB_PERF_EN
    .perf_issue(perf_issue), .perf_idle(perf_idle),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [ZW-1:0] mfun(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [AW+BW-1:0] p;
    p = a * b;
    return p[ZW-1:0];
  endfunction

  // Multiplier stand-in: product appears LAT cycles after the operands are presented.
  logic [ZW-1:0] zpipe [LAT];
  initial for (int k = 0; k < LAT; k++) zpipe[k] = '0;
  always @(posedge clk) begin
    zpipe[0] <= mfun(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) zpipe[k] <= zpipe[k-1];
  end
  assign mul_z = zpipe[LAT-1];

  typedef struct {int due; int id; logic [ZW-1:0] z;} pend_t;
  pend_t           q[$];
  int              rr_m = 0, gnt_m = -1, cyc = 0, rsp_cnt = 0;
  logic [NREQ-1:0] exp_ready = '0, exp_rsp_v = '0;
  logic [ZW-1:0]   exp_rsp_z = '0;
  logic [AW-1:0]   exp_mul_a = '0;
  logic [BW-1:0]   exp_mul_b = '0;
  logic [31:0]     pi_m = '0, pd_m = '0;
  int              checks = 0, fails = 0;

  function automatic logic exp_busy();
    return (q.size() > 0) || (exp_rsp_v != '0);
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*AW +: AW] = {$urandom, $urandom};
      req_b[i*BW +: BW] = {$urandom, $urandom};
    end
  endtask

  task automatic apply(input logic [NREQ-1:0] v, input logic r);
    req_valid = v;
    rstn = r;
    #2;
    gnt_m = -1;
    if (r)
      for (int k = 0; k < NREQ; k++)
        if (gnt_m < 0 && v[(rr_m + k) % NREQ]) gnt_m = (rr_m + k) % NREQ;
    exp_ready = '0;
    if (gnt_m >= 0) exp_ready[gnt_m] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      q.delete();
      rr_m = 0; exp_mul_a = '0; exp_mul_b = '0; exp_rsp_v = '0; exp_rsp_z = '0;
      pi_m = '0; pd_m = '0;
    end else begin
      exp_rsp_v = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_rsp_v[q[0].id] = 1'b1;
        exp_rsp_z = q[0].z;
        void'(q.pop_front());
        rsp_cnt++;
      end
      if (gnt_m >= 0) begin
        exp_mul_a = req_a[gnt_m*AW +: AW];
        exp_mul_b = req_b[gnt_m*BW +: BW];
        q.push_back('{cyc + LAT + 1, gnt_m, mfun(exp_mul_a, exp_mul_b)});
        rr_m = (gnt_m + 1) % NREQ;
        pi_m++;
      end else begin
        exp_mul_a = '0; exp_mul_b = '0;
        pd_m++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    apply('0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    apply('1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply('1, 1'b0);
      checks++;
      if ({req_ready, rsp_valid, busy, mul_a, mul_b, rsp_z} !== '0) begin
        fails++;
        $display("FAIL reset: ready=%b rsp_v=%b busy=%b mul_a=%h mul_b=%h rsp_z=%h, all required 0",
                 req_ready, rsp_valid, busy, mul_a, mul_b, rsp_z);
      end
      tick();
    end
  endtask

  task automatic test_single();
    int acc_cyc, seen_cyc, hits, busy_n;
    logic [ZW-1:0] seen_z;
    do_reset();
    hits = 0; busy_n = 0; seen_cyc = -1; seen_z = '0;
    for (int i = 0; i < 10; i++) begin apply('0, 1'b1); tick(); end
    req_a[2*AW +: AW] = 64'd3;
    req_b[2*BW +: BW] = 64'd5;
    apply(4'b0100, 1'b1);
    checks++;
    if (req_ready !== 4'b0100) begin
      fails++; $display("FAIL single_grant: ready=%b required 0100", req_ready);
    end
    tick();
    acc_cyc = cyc;
    for (int i = 0; i < 60; i++) begin
      apply('0, 1'b1);
      checks++;
      if ({req_ready, rsp_valid, busy} !== {exp_ready, exp_rsp_v, exp_busy()} ||
          {mul_a, mul_b, rsp_z} !== {exp_mul_a, exp_mul_b, exp_rsp_z}) begin
        fails++;
        $display("FAIL single_cycle%0d: ready=%b rsp_v=%b busy=%b z=%h mul=%h/%h required %b %b %b %h %h/%h",
                 i, req_ready, rsp_valid, busy, rsp_z, mul_a, mul_b,
                 exp_ready, exp_rsp_v, exp_busy(), exp_rsp_z, exp_mul_a, exp_mul_b);
      end
      if (rsp_valid !== 4'b0000) begin hits++; seen_cyc = cyc; seen_z = rsp_z; end
      if (busy === 1'b1) busy_n++;
      tick();
    end
    checks++;
    if (hits != 1 || seen_cyc - acc_cyc != LAT + 1 || seen_z !== 64'd15) begin
      fails++;
      $display("FAIL single_latency: hits=%0d delay=%0d z=%0d required 1 %0d 15",
               hits, seen_cyc - acc_cyc, seen_z, LAT + 1);
    end
    checks++;
    if (busy_n != LAT + 2) begin
      fails++; $display("FAIL single_busy: busy cycles=%0d required %0d", busy_n, LAT + 2);
    end
  endtask

  task automatic test_rotate();
    int j;
    do_reset();
    j = 0;
    for (int k = 0; k < 40 + LAT + 10; k++) begin
      rand_ops();
      apply((k < 40) ? 4'b1111 : 4'b0000, 1'b1);
      checks++;
      if ({req_ready, rsp_valid, busy} !== {exp_ready, exp_rsp_v, exp_busy()} ||
          {mul_a, mul_b, rsp_z} !== {exp_mul_a, exp_mul_b, exp_rsp_z}) begin
        fails++;
        $display("FAIL rotate_model%0d: ready=%b rsp_v=%b busy=%b z=%h required %b %b %b %h",
                 k, req_ready, rsp_valid, busy, rsp_z, exp_ready, exp_rsp_v, exp_busy(), exp_rsp_z);
      end
      if (k < 40) begin
        checks++;
        if (req_ready !== 4'(1 << (k % 4))) begin
          fails++; $display("FAIL rotate_grant%0d: ready=%b required %b", k, req_ready, 4'(1 << (k % 4)));
        end
      end
      if (rsp_valid !== 4'b0000) begin
        checks++;
        if (rsp_valid !== 4'(1 << (j % 4))) begin
          fails++; $display("FAIL rotate_rsp_order%0d: rsp_v=%b required %b", j, rsp_valid, 4'(1 << (j % 4)));
        end
        j++;
      end
      tick();
    end
    checks++;
    if (j != 40) begin fails++; $display("FAIL rotate_rsp_count: got %0d required 40", j); end
  endtask

  task automatic test_sparse();
    logic [NREQ-1:0] want;
    do_reset();
    apply(4'b0010, 1'b1);
    tick();
    for (int k = 0; k < 12 + LAT + 4; k++) begin
      rand_ops();
      apply((k < 12) ? 4'b1010 : 4'b0000, 1'b1);
      want = (k >= 12) ? 4'b0000 : (k % 2 == 0) ? 4'b1000 : 4'b0010;
      checks++;
      if (req_ready !== want) begin
        fails++; $display("FAIL sparse_grant%0d: ready=%b required %b", k, req_ready, want);
      end
      checks++;
      if ({rsp_valid, busy, rsp_z} !== {exp_rsp_v, exp_busy(), exp_rsp_z}) begin
        fails++;
        $display("FAIL sparse_rsp%0d: rsp_v=%b busy=%b z=%h required %b %b %h",
                 k, rsp_valid, busy, rsp_z, exp_rsp_v, exp_busy(), exp_rsp_z);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int base, late, k;
    logic hit;
    do_reset();
    base = rsp_cnt;
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      apply('1, 1'b1);
      checks++;
      if ({req_ready, mul_a, mul_b} !== {exp_ready, exp_mul_a, exp_mul_b}) begin
        fails++; $display("FAIL b2b_issue%0d: ready=%b mul_a=%h required %b %h", i, req_ready, mul_a, exp_ready, exp_mul_a);
      end
      tick();
    end
    hit = 1'b0;
    for (k = 0; k < 100 && !hit; k++) begin
      apply('0, 1'b1);
      checks++;
      if ({rsp_valid, busy, rsp_z} !== {exp_rsp_v, exp_busy(), exp_rsp_z}) begin
        fails++; $display("FAIL b2b_rsp%0d: rsp_v=%b z=%h required %b %h", k, rsp_valid, rsp_z, exp_rsp_v, exp_rsp_z);
      end
      tick();
      if (rsp_cnt - base == 10) hit = 1'b1;
    end
    checks++;
    if (!hit) begin fails++; $display("FAIL b2b_timeout: responses=%0d required 10", rsp_cnt - base); end
    apply('0, 1'b0);
    tick();
    late = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      apply('0, 1'b1);
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) late++;
      tick();
    end
    checks++;
    if (late != 0) begin fails++; $display("FAIL b2b_after_reset: %0d cycles with rsp/busy, required 0", late); end
    rand_ops();
    apply('1, 1'b1);
    checks++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL b2b_first_grant: ready=%b required 0001", req_ready); end
    tick();
  endtask

  task automatic test_idle();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      rand_ops();
      apply('0, 1'b1);
      if ({mul_a, mul_b, rsp_valid, busy, req_ready} !== '0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL idle: %0d non-idle cycles, required 0", bad); end
`ifdef QPMM_ARB_PERF_EN
    checks++;
    if (perf_idle !== 32'd100 || perf_issue !== 32'd0) begin
      fails++; $display("FAIL idle_perf: idle=%0d issue=%0d required 100 0", perf_idle, perf_issue);
    end
`endif
  endtask

  task automatic test_random();
    logic r;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      r = (k < 340) ? ($urandom_range(0, 99) != 0) : 1'b1;
      apply((k < 340) ? 4'($urandom_range(0, 15)) : 4'b0000, r);
      checks++;
      if ({req_ready, rsp_valid, busy} !== {exp_ready, exp_rsp_v, exp_busy()} ||
          {mul_a, mul_b, rsp_z} !== {exp_mul_a, exp_mul_b, exp_rsp_z}) begin
        fails++;
        $display("FAIL random%0d: ready=%b rsp_v=%b busy=%b z=%h mul_a=%h required %b %b %b %h %h",
                 k, req_ready, rsp_valid, busy, rsp_z, mul_a, exp_ready, exp_rsp_v, exp_busy(), exp_rsp_z, exp_mul_a);
      end
      tick();
    end
`ifdef QPMM_ARB_PERF_EN
    checks++;
    if (perf_issue !== pi_m || perf_idle !== pd_m) begin
      fails++; $display("FAIL random_perf: issue=%0d idle=%0d required %0d %0d", perf_issue, perf_idle, pi_m, pd_m);
    end
`endif
  endtask

`ifdef QPMM_ARB_PERF_EN
  task automatic test_wrap();
    do_reset();
    apply('0, 1'b1);
    force dut.perf_issue = 32'hFFFF_FFFF;
    #1;
    release dut.perf_issue;
    apply(4'b0100, 1'b1);
    tick();
    checks++;
    if (perf_issue !== 32'd0) begin fails++; $display("FAIL perf_wrap: issue=%h required 00000000", perf_issue); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_sparse();
    test_back_to_back();
    test_idle();
    test_random();
`ifdef QPMM_ARB_PERF_EN
    test_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/qpmm_arbiter.md
# qpmm_arbiter

Round-robin front end that lets up to NREQ independent requesters share one fully pipelined QPMM Montgomery multiplier instance, such as the BN254 d0 multiplier. The multiplier has no valid or stall signalling. This block therefore does four things:
- grants at most one operand pair per cycle;
- registers the operands into the multiplier;
- carries a requester tag alongside the multiplier's fixed latency;
- steers each product back to its requester.

It sits between the pairing-level schedulers and the multiplier.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 286, width of operand A (multiplier A-port type)
- BW, 286, width of operand B (multiplier B-port type)
- ZW, 286, width of multiplier result Z
- LAT, 46, multiplier latency in cycles from A/B sampled to matching Z valid; must equal the instantiated multiplier

Ports:
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  reset; synchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot grant; combinational from req_valid and the RR pointer
- req_a  in  NREQ*AW  operand A; requester i in slice [i*AW +: AW]
- req_b  in  NREQ*BW  operand B; requester i in slice [i*BW +: BW]
- mul_a  out  AW  registered operand A to the multiplier
- mul_b  out  BW  registered operand B to the multiplier
- mul_z  in  ZW  multiplier result
- rsp_valid  out  NREQ  one-hot response strobe, one cycle wide
- rsp_z  out  ZW  registered result, shared by all requesters
- busy  out  1  high while any issued operation is still in flight

## Operation
- Arbitration:
  - Round-robin pointer rr ranges 0..NREQ-1.
  - The grant goes to the first i with req_valid[i]=1, searching from rr upward with wrap.
  - req_ready[i]=1 only for that i; all zeros when no request.
- Accept: a request is accepted when req_valid[i] & req_ready[i] in a cycle.
  - At that edge mul_a/mul_b load the selected operands.
  - rr is set to (i+1) mod NREQ.
  - No accept: mul_a/mul_b load zero and rr holds.
- Tag pipe:
  - Shift register, LAT+1 stages, each stage {v, id[clog2(NREQ)-1:0]}.
  - Stage 0 loads {accept, i} every cycle; the stages shift unconditionally.
  - The multiplier cannot stall, so the block never back-pressures the output.
- Response:
  - When the last tag stage has v=1, next edge: rsp_z <= mul_z and rsp_valid <= onehot(id).
  - Otherwise rsp_valid <= 0 and rsp_z holds.
  - Requesters must accept every response; there is no rsp_ready.
- busy = OR of all tag v bits and rsp_valid.
- Requester i may keep req_valid high across consecutive grants. Under contention it gets one grant every NREQ cycles at most.
- Responses return in issue order; the ids tell the requesters apart.

## Timing
- Reset (rstn=0 at an edge):
  - rr=0, all tag v=0.
  - mul_a=0, mul_b=0, rsp_valid=0, rsp_z=0, busy=0.
  - req_ready is forced to 0 while rstn=0.
- Reset mid-operation: all in-flight tags are dropped. Multiplier outputs arriving later are ignored; no rsp_valid is produced for them.
- Latency: accept at edge t, so mul_a/mul_b are valid in cycle t+1, and rsp_valid/rsp_z are valid in cycle t+LAT+2.
- Throughput: one accept per cycle, back-to-back, with no bubbles.
- The first cycle after reset release can accept.
- Simultaneous events: an accept and a response in the same cycle are independent; both proceed.
- Single requester: a requester holding req_valid is granted every cycle.

## Configuration
- Macro QPMM_ARB_PERF_EN.
- Defined: adds two 32-bit output ports, perf_issue and perf_idle.
  - perf_issue increments on each accept.
  - perf_idle increments on each cycle with no accept.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, LAT=46, NREQ=4, req 2 issues A=3, B=5 at cycle 10 with a behavioural multiplier model:
  - rsp_valid=4'b0100 in cycle 58 only, rsp_z = model(3,5);
  - busy is high for cycles 11..58.
- All four requesters are valid continuously from cycle 0:
  - grants rotate 0,1,2,3,0,…;
  - responses arrive in the same order, one per cycle, with correct ids.
- Requesters 1 and 3 only, with rr=2:
  - the first grant goes to 3, then 1, then 3;
  - requester 0 never gets req_ready.
- 20 back-to-back issues, then rstn=0 for one cycle at the 10th response:
  - no further rsp_valid after reset;
  - the next issue after reset is granted to requester 0 first.
- Idle pipeline: no req_valid for 100 cycles gives mul_a=mul_b=0, rsp_valid=0, busy=0. With QPMM_ARB_PERF_EN defined, perf_idle=100 and perf_issue=0.
- Counter wrap with QPMM_ARB_PERF_EN: preload perf_issue to 32'hFFFF_FFFF via force, then one accept gives perf_issue=0.
